imem_fetch_sequencer: RTL and testbench

Controller that owns the instruction memory's single address port and sequences its use. After reset it grants the port to a program loader (BOOT), which writes instruction words into memory. Once the loader signals completion it runs the fetch stream (RUN): it holds the program counter, applies stall and branch redirects, and presents registered instruction/PC pairs to decode. A misaligned or out-of-range fetch address stops fetch in HALT with `fault` raised.

---
 rtl/imem_fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
// Owns the single address port of the instruction memory. After reset the
// port belongs to the program loader (BOOT). When the loader signals it is
// done, the block fetches one word per cycle (RUN) and presents registered
// pc/instr pairs to decode, honouring stall and branch redirects. A bad
// fetch or branch address parks the block in HALT with a sticky fault.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_load_*            loader write request / address / data / done pulse
//   o_load_ready        loader owns the memory port (BOOT only)
//   o_mem_*             memory address, write enable, write data
//   i_mem_rdata         memory read word, combinational from o_mem_addr
//   i_stall             hold the fetch pipeline this cycle
//   i_branch_*          redirect request and target byte address
//   o_pc, o_instr       registered fetched word and its byte address
//   o_instr_valid       o_pc/o_instr valid this cycle
//   o_fault             sticky fetch fault
//   o_state             current FSM state (debug: 0 BOOT, 1 RUN, 2 HALT)
//
// Loader handshake: o_load_ready is a mode flag, not back-pressure. Every
// cycle with o_load_ready=1 and i_load_valid=1 is one write attempt, and it
// completes in that cycle if the address is word-aligned and inside the
// memory; otherwise it is dropped without notice. i_load_done is sampled only
// while o_load_ready=1, and a write in the same cycle is still performed.
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DEPTH    = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load_valid,
  input  logic [31:0] i_load_addr,
  input  logic [31:0] i_load_data,
  input  logic        i_load_done,
  output logic        o_load_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic        o_fault,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // First byte address past the end of memory; compared over all 32 bits so
  // high address bits can never alias back into range.
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
  endfunction

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_fault;

  logic w_load_ok;
  logic w_target_ok;
  logic w_fetch_ok;

  assign w_load_ok   = addr_ok(i_load_addr);
  assign w_target_ok = addr_ok(i_branch_target);
  assign w_fetch_ok  = addr_ok(r_fetch_pc);

  // Memory port steering depends only on the registered state (plus the
  // loader's own request while in BOOT).
  always_comb begin
    o_load_ready = 1'b0;
    o_mem_addr   = 32'd0;
    o_mem_we     = 1'b0;
    o_mem_wdata  = 32'd0;
    case (r_state)
      S_BOOT: begin
        o_load_ready = 1'b1;
        o_mem_addr   = i_load_addr;
        o_mem_we     = i_load_valid && w_load_ok;
        o_mem_wdata  = i_load_data;
      end
      S_RUN: begin
        o_mem_addr = r_fetch_pc;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_pc          <= 32'd0;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (i_load_done) begin
            r_state    <= S_RUN;
            r_fetch_pc <= RESET_PC;
          end
        end
        S_RUN: begin
          if (i_branch_taken) begin
            // Redirect wins over stall; the word already on the bus is
            // discarded, giving exactly one bubble.
            r_instr_valid <= 1'b0;
            if (w_target_ok) begin
              r_fetch_pc <= i_branch_target;
            end else begin
              r_state <= S_HALT;
              r_fault <= 1'b1;
            end
          end else if (i_stall) begin
            // Everything holds, including o_instr_valid.
          end else if (!w_fetch_ok) begin
            r_state       <= S_HALT;
            r_fault       <= 1'b1;
            r_instr_valid <= 1'b0;
          end else begin
            r_instr       <= i_mem_rdata;
            r_pc          <= r_fetch_pc;
            r_instr_valid <= 1'b1;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
          end
        end
        S_HALT: begin
          r_instr_valid <= 1'b0;
          r_fault       <= 1'b1;
        end
        default: begin
          r_state <= S_HALT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_fault       = r_fault;
  assign o_state       = r_state;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: loads a program through the loader port
// into a bench-owned memory, then exercises fetch, stall, branch, faults and
// reset. Fetched (pc, instr) pairs are checked against an expected queue.
module tb_imem_fetch_sequencer;

  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fault;
  logic [1:0]  state;

  imem_fetch_sequencer #(.RESET_PC(32'd0), .DEPTH(DEPTH)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_load_valid    (load_valid),
    .i_load_addr     (load_addr),
    .i_load_data     (load_data),
    .i_load_done     (load_done),
    .o_load_ready    (load_ready),
    .o_mem_addr      (mem_addr),
    .o_mem_we        (mem_we),
    .o_mem_wdata     (mem_wdata),
    .i_mem_rdata     (mem_rdata),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_pc            (pc),
    .o_instr         (instr),
    .o_instr_valid   (instr_valid),
    .o_fault         (fault),
    .o_state         (state)
  );

  // Instruction memory owned by the bench.
  logic [31:0] tb_mem [0:DEPTH-1];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = tb_mem[mem_addr[7:2]];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        mon_held = 1'b0;
  logic [63:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h0198_06B3;
      2:       return 32'h4034_02B3;
      11:      return 32'h0094_8663;
      default: return 32'hA500_0000 | 32'(i << 8) | 32'(i);
    endcase
  endfunction

  task automatic push_fetch(input logic [31:0] a);
    exp_q.push_back({a, word_of(int'(a >> 2))});
  endtask

  // A new output is one with instr_valid that was not merely held by a stall.
  always @(negedge clk) begin
    if (instr_valid && !mon_held) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream: got pc=%h instr=%h, expected no output", pc, instr);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({pc, instr} !== mon_exp) begin
          n_fail++;
          $display("FAIL stream: got pc=%h instr=%h expected pc=%h instr=%h",
                   pc, instr, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
    mon_held = stall && !branch_taken;
  end

  // ---------------- driver ----------------
  typedef struct {
    logic        lv;
    logic [31:0] la;
    logic [31:0] ld;
    logic        done;
    logic        st;
    logic        br;
    logic [31:0] bt;
    logic        exp_we;
  } boot_vec_t;

  boot_vec_t tbl[$];

  task automatic add_vec(input logic lv, input logic [31:0] la, input logic [31:0] ld,
                         input logic done, input logic st, input logic br,
                         input logic [31:0] bt, input logic exp_we);
    boot_vec_t v;
    v.lv = lv; v.la = la; v.ld = ld; v.done = done;
    v.st = st; v.br = br; v.bt = bt; v.exp_we = exp_we;
    tbl.push_back(v);
  endtask

  task automatic idle();
    load_valid = 1'b0; load_addr = 32'd0; load_data = 32'd0; load_done = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Boot vector table: full program load, dropped writes, ignored
    // fetch controls, and a final write coinciding with load_done.
    for (int i = 0; i < DEPTH - 1; i++)
      add_vec(1'b1, 32'(i * 4), word_of(i), 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    add_vec(1'b1, 32'd2,         32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    add_vec(1'b1, 32'd256,       32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    add_vec(1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    add_vec(1'b0, 32'd16,        32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 32'd6, 1'b0);
    add_vec(1'b1, 32'd252,       word_of(63),   1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Reset
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault",       32'(fault),       32'd0);
    chk("rst_pc",          pc,               32'd0);
    chk("rst_instr",       instr,            32'd0);
    chk("rst_load_ready",  32'(load_ready),  32'd1);
    chk("rst_state",       32'(state),       32'd0);
    rst = 1'b0;

    // Boot table
    foreach (tbl[k]) begin
      load_valid = tbl[k].lv; load_addr = tbl[k].la; load_data = tbl[k].ld;
      load_done = tbl[k].done; stall = tbl[k].st; branch_taken = tbl[k].br;
      branch_target = tbl[k].bt;
      #1;
      chk("boot_mem_we",     32'(mem_we),     32'(tbl[k].exp_we));
      chk("boot_mem_addr",   mem_addr,        tbl[k].la);
      chk("boot_mem_wdata",  mem_wdata,       tbl[k].ld);
      chk("boot_load_ready", 32'(load_ready), 32'd1);
      if (tbl[k].done) begin
        for (int a = 0; a < 20; a += 4) push_fetch(32'(a));
      end
      tick();
    end

    // First RUN cycle: loader requests are ignored, fetch address is RESET_PC.
    idle();
    load_valid = 1'b1; load_addr = 32'd0; load_data = 32'hFFFF_FFFF;
    #1;
    chk("run_state",       32'(state),       32'd1);
    chk("run_load_ready",  32'(load_ready),  32'd0);
    chk("run_mem_we",      32'(mem_we),      32'd0);
    chk("run_mem_wdata",   mem_wdata,        32'd0);
    chk("run_mem_addr",    mem_addr,         32'd0);
    chk("run_first_valid", 32'(instr_valid), 32'd0);
    chk("mem0_untouched",  tb_mem[0],        32'd0);
    chk("mem63_with_done", tb_mem[63],       word_of(63));
    idle();
    tick();
    chk("latency_valid", 32'(instr_valid), 32'd1);
    chk("latency_pc",    pc,               32'd0);
    tick();
    chk("pre_stall_pc", pc, 32'd4);

    // Stall for three cycles while pc=4.
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_pc",    pc,               32'd4);
      chk("stall_instr", instr,            word_of(1));
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("post_stall_pc", pc, 32'd8);
    tick();
    tick();
    chk("fetch_addr_20", mem_addr, 32'd20);

    // Branch to 44 while fetching 20: one bubble, then the target word.
    branch_taken = 1'b1; branch_target = 32'd44;
    push_fetch(32'd44);
    tick();
    branch_taken = 1'b0;
    chk("br_bubble_valid", 32'(instr_valid), 32'd0);
    chk("br_bubble_pc",    pc,               32'd16);
    chk("br_mem_addr",     mem_addr,         32'd44);
    tick();
    chk("br_target_valid", 32'(instr_valid), 32'd1);
    chk("br_target_pc",    pc,               32'd44);
    chk("br_target_instr", instr,            32'h0094_8663);

    // Branch and stall together: branch wins.
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'd8;
    push_fetch(32'd8);
    tick();
    idle();
    chk("brst_valid",    32'(instr_valid), 32'd0);
    chk("brst_mem_addr", mem_addr,         32'd8);
    tick();
    chk("brst_pc",    pc,    32'd8);
    chk("brst_instr", instr, word_of(2));

    // Misaligned branch target -> HALT.
    branch_taken = 1'b1; branch_target = 32'd6;
    tick();
    chk("bfault_fault", 32'(fault),       32'd1);
    chk("bfault_valid", 32'(instr_valid), 32'd0);
    chk("bfault_state", 32'(state),       32'd2);
    chk("bfault_addr",  mem_addr,         32'd0);
    branch_target = 32'd44; stall = 1'b1; load_done = 1'b1;
    tick();
    tick();
    idle();
    chk("halt_sticky_fault", 32'(fault),       32'd1);
    chk("halt_sticky_state", 32'(state),       32'd2);
    chk("halt_valid",        32'(instr_valid), 32'd0);
    chk("halt_load_ready",   32'(load_ready),  32'd0);
    chk("halt_queue_empty",  32'(exp_q.size()), 32'd0);

    // Reset out of HALT, then reset in the middle of RUN.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_fault",      32'(fault),      32'd0);
    chk("rst2_load_ready", 32'(load_ready), 32'd1);
    load_done = 1'b1;
    push_fetch(32'd0);
    push_fetch(32'd4);
    tick();
    load_done = 1'b0;
    tick();
    tick();
    chk("midrun_valid", 32'(instr_valid), 32'd1);
    chk("midrun_pc",    pc,               32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst3_valid",      32'(instr_valid), 32'd0);
    chk("rst3_fault",      32'(fault),       32'd0);
    chk("rst3_load_ready", 32'(load_ready),  32'd1);
    chk("rst3_pc",         pc,               32'd0);
    load_done = 1'b1;
    push_fetch(32'd0);
    tick();
    load_done = 1'b0;
    tick();
    chk("refetch_valid", 32'(instr_valid), 32'd1);
    chk("refetch_pc",    pc,               32'd0);

    // Sequential fetch off the end of memory: 252 is output, then fault.
    branch_taken = 1'b1; branch_target = 32'd240;
    for (int a = 240; a < 256; a += 4) push_fetch(32'(a));
    tick();
    idle();
    for (int a = 240; a < 256; a += 4) tick();
    chk("end_pc",    pc,               32'd252);
    chk("end_valid", 32'(instr_valid), 32'd1);
    chk("end_fault", 32'(fault),       32'd0);
    tick();
    chk("oor_fault", 32'(fault),       32'd1);
    chk("oor_valid", 32'(instr_valid), 32'd0);
    chk("oor_state", 32'(state),       32'd2);
    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
